// File: rtl/audio_out_pkg.sv
// Shared definitions for the multichannel 1-bit audio output stage.
//   MODE_PWM / MODE_SDM : encodings of the run-time modulator select
//   level_width()       : width of a FIFO occupancy count (holds 0..depth)
package audio_out_pkg;

  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SDM = 1'b1;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags.
//   clk, aclr        : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      : write strobe/data, ignored while full
//   pop, rdata       : read strobe, ignored while empty; rdata shows the head
//   full, empty      : registered, reflect the post-edge state
//   level            : registered number of entries held
module sync_fifo
  import audio_out_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  logic [LW-1:0]    level_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)      level_nxt = level + LW'(1);
    else if (do_pop && !do_push) level_nxt = level - LW'(1);
  end

  // Storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/audio_multichannel_out.sv
// N-channel PCM to 1-bit audio output stage (PWM or first-order sigma-delta).
//   clk, aclr          : clock, asynchronous active-low reset
//   enable             : runs the frame counter and modulators; 0 parks outputs low
//   mode               : 0 = PWM, 1 = SDM, taken at frame boundaries only
//   pcm_valid/frame    : push of one packed frame, channel 0 in the MSBs
//   fifo_full/level    : registered FIFO occupancy
//   mute               : per-channel force-low
//   status_clr         : clears the sticky overflow/underrun flags
//   overflow/underrun  : sticky error flags
//   audio_out          : registered 1-bit outputs
// Per-channel vectors (mute, audio_out) follow the frame packing: channel c
// sits at bit CHANNELS-1-c, so channel 0 is the MSB.
module audio_multichannel_out
  import audio_out_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                aclr,
  input  logic                                enable,
  input  logic                                mode,
  input  logic                                pcm_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]    pcm_frame,
  output logic                                fifo_full,
  output logic [level_width(FIFO_DEPTH)-1:0]  fifo_level,
  input  logic [CHANNELS-1:0]                 mute,
  input  logic                                status_clr,
  output logic                                overflow,
  output logic                                underrun,
  output logic [CHANNELS-1:0]                 audio_out
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int FW = CHANNELS * SAMPLE_WIDTH;

  logic [W-1:0]  fc;
  logic          boundary, pop, fifo_empty, mode_act;
  logic [FW-1:0] head;

  // Last cycle of a frame; the pop lands so the new samples are live at fc=0.
  assign boundary = enable && (fc == '1);
  assign pop      = boundary && !fifo_empty;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .aclr  (aclr),
    .push  (pcm_valid),
    .wdata (pcm_frame),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)        fc <= '0;
    else if (!enable) fc <= '0;
    else              fc <= fc + W'(1);
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)         mode_act <= MODE_PWM;
    else if (boundary) mode_act <= mode;
  end

  // Set events take priority over a coincident clear.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= (pcm_valid && fifo_full) || (overflow && !status_clr);
      underrun <= (boundary && fifo_empty) || (underrun && !status_clr);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [W-1:0] samp;
    logic [W:0]   acc;
    logic         mod_bit;
    logic         out_r;

    // An underrun leaves samp untouched, so the last sample keeps playing.
    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr)    samp <= '0;
      else if (pop) samp <= head[(CHANNELS-1-c)*W +: W];
    end

    // Accumulator bit W is the carry of the latest add; the low bits are
    // the running remainder.
    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr)        acc <= '0;
      else if (!enable) acc <= '0;
      else              acc <= {1'b0, acc[W-1:0]} + {1'b0, samp};
    end

    assign mod_bit = (mode_act == MODE_SDM) ? acc[W] : (fc < samp);

    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) out_r <= 1'b0;
      else       out_r <= enable && mod_bit && !mute[CHANNELS-1-c];
    end

    assign audio_out[CHANNELS-1-c] = out_r;
  end

endmodule

// File: tb/tb_audio_multichannel_out.sv
module tb_audio_multichannel_out;

  logic        clk = 1'b0;
  logic        aclr, enable, mode, pcm_valid, status_clr;
  logic [15:0] pcm_frame;
  logic [1:0]  mute;
  logic        fifo_full, overflow, underrun;
  logic [2:0]  fifo_level;
  logic [1:0]  audio_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_multichannel_out #(.CHANNELS(2), .SAMPLE_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .enable     (enable),
    .mode       (mode),
    .pcm_valid  (pcm_valid),
    .pcm_frame  (pcm_frame),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .mute       (mute),
    .status_clr (status_clr),
    .overflow   (overflow),
    .underrun   (underrun),
    .audio_out  (audio_out)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers (stimulus / observation only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [15:0] f);
    pcm_valid = 1'b1;
    pcm_frame = f;
    tick();
    pcm_valid = 1'b0;
  endtask

  task automatic clear_flags();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  // Records 256 consecutive output cycles; bit i of o0/o1 = cycle i.
  // ch0 is audio_out[1], ch1 is audio_out[0].
  task automatic capture(output logic [255:0] o0, output logic [255:0] o1);
    for (int i = 0; i < 256; i++) begin
      tick();
      o0[i] = audio_out[1];
      o1[i] = audio_out[0];
    end
  endtask

  // Reference PWM frame: high for the first s cycles of 256.
  function automatic logic [255:0] pwm_pat(input int s);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < 256; j++) v[j] = (j < s);
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0]  s0;
    logic [15:0] f;
    aclr = 1'b1;
    #2 aclr = 1'b0;
    #2;
    total++;
    if (audio_out !== 2'b00 || fifo_level !== 3'd0 || fifo_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: out=%b level=%0d full=%b want 00/0/0", audio_out, fifo_level, fifo_full);
    end
    total++;
    if (overflow !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ovf=%b unr=%b want 0/0", overflow, underrun);
    end
    @(negedge clk) aclr = 1'b1;
    tick();
    s0 = 8'($urandom_range(100, 200));
    push({s0, 8'($urandom_range(0, 255))});
    for (int k = 0; k < 4; k++) begin
      f = 16'($urandom);
      push(f);
    end
    total++;
    if (fifo_level !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL reset_prefill: level=%0d full=%b ovf=%b want 4/1/1", fifo_level, fifo_full, overflow);
    end
    enable = 1'b1;
    run_ticks(256);   // first boundary pops the s0 frame
    run_ticks(50);    // now mid-frame at fc=50, output reflects fc=49
    total++;
    if (audio_out[1] !== 1'b1 || fifo_level !== 3'd3) begin
      bad++;
      $display("FAIL reset_midframe_setup: ch0=%b level=%0d want 1/3", audio_out[1], fifo_level);
    end
    aclr = 1'b0;
    #1;
    total++;
    if (audio_out !== 2'b00 || fifo_level !== 3'd0 || fifo_full !== 1'b0 ||
        overflow !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: out=%b level=%0d full=%b ovf=%b unr=%b want all 0",
               audio_out, fifo_level, fifo_full, overflow, underrun);
    end
    enable = 1'b0;
    @(negedge clk) aclr = 1'b1;
    tick();
  endtask

  task automatic test_pwm();
    logic [7:0]   s0, s1;
    logic [255:0] a0, a1, b0, b1;
    s0 = 8'($urandom_range(1, 254));
    s1 = 8'($urandom_range(0, 255));
    push({s0, 8'd0});
    push({8'd255, s1});
    mode   = 1'b0;
    enable = 1'b1;
    run_ticks(256);
    capture(a0, a1);
    capture(b0, b1);
    enable = 1'b0;
    total++;
    if (a0 !== pwm_pat(s0)) begin
      bad++;
      $display("FAIL pwm_ch0_mid: got=%0d ones want=%0d leading ones (s=%0d)", $countones(a0), s0, s0);
    end
    total++;
    if (a1 !== '0) begin
      bad++;
      $display("FAIL pwm_ch1_zero: got=%0d ones want 0", $countones(a1));
    end
    total++;
    if (b0 !== pwm_pat(255)) begin
      bad++;
      $display("FAIL pwm_ch0_full: got=%0d ones last=%b want 255 ones last=0", $countones(b0), b0[255]);
    end
    total++;
    if (b1 !== pwm_pat(s1)) begin
      bad++;
      $display("FAIL pwm_ch1_rand: got=%0d ones want=%0d leading ones", $countones(b1), s1);
    end
    clear_flags();
  endtask

  task automatic test_sdm();
    logic [7:0]   s0, r0, r1;
    logic [255:0] c0, c1, d0, d1;
    s0 = 8'($urandom_range(1, 128));
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    push({s0, 8'd255});
    push({r0, r1});
    mode   = 1'b1;
    enable = 1'b1;
    run_ticks(257);
    capture(c0, c1);
    capture(d0, d1);
    enable = 1'b0;
    total++;
    if ($countones(c0) != int'(s0)) begin
      bad++;
      $display("FAIL sdm_ch0_density: got=%0d want=%0d", $countones(c0), s0);
    end
    total++;
    if ($countones(c1) != 255) begin
      bad++;
      $display("FAIL sdm_ch1_density: got=%0d want=255", $countones(c1));
    end
    total++;
    if ((c0 & (c0 >> 1)) !== '0) begin
      bad++;
      $display("FAIL sdm_ch0_spread: consecutive ones seen, want none (s=%0d)", s0);
    end
    total++;
    if ($countones(d0) != int'(r0) || $countones(d1) != int'(r1)) begin
      bad++;
      $display("FAIL sdm_rand_density: got=%0d/%0d want=%0d/%0d", $countones(d0), $countones(d1), r0, r1);
    end
    clear_flags();
  endtask

  task automatic test_overflow();
    logic [15:0]  f [6];
    logic [255:0] o0, o1;
    for (int k = 0; k < 6; k++) f[k] = 16'($urandom);
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(f[k]);
      total++;
      if (fifo_level !== 3'(k + 1) || fifo_full !== (k == 3) || overflow !== 1'b0) begin
        bad++;
        $display("FAIL ovf_fill%0d: level=%0d full=%b ovf=%b want %0d/%b/0",
                 k, fifo_level, fifo_full, overflow, k + 1, (k == 3));
      end
    end
    push(f[4]);
    total++;
    if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      bad++;
      $display("FAIL ovf_set: ovf=%b level=%0d want 1/4", overflow, fifo_level);
    end
    status_clr = 1'b1;
    push(f[5]);
    status_clr = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clr_vs_set: ovf=%b want 1", overflow);
    end
    clear_flags();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
    enable = 1'b1;
    run_ticks(256);
    for (int k = 0; k < 4; k++) begin
      capture(o0, o1);
      total++;
      if (o0 !== pwm_pat(f[k][15:8]) || o1 !== pwm_pat(f[k][7:0])) begin
        bad++;
        $display("FAIL ovf_play%0d: got=%0d/%0d ones want=%0d/%0d",
                 k, $countones(o0), $countones(o1), f[k][15:8], f[k][7:0]);
      end
      if (k == 2) begin
        total++;
        if (underrun !== 1'b0) begin
          bad++;
          $display("FAIL unr_early: unr=%b want 0", underrun);
        end
      end
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL unr_set: unr=%b want 1", underrun);
    end
    clear_flags();
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL unr_clear: unr=%b want 0", underrun);
    end
    run_ticks(254);   // now in the last cycle of the frame
    clear_flags();    // coincides with an empty boundary
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL unr_clr_vs_set: unr=%b want 1", underrun);
    end
    capture(o0, o1);
    enable = 1'b0;
    total++;
    if (o0 !== pwm_pat(f[3][15:8]) || o1 !== pwm_pat(f[3][7:0])) begin
      bad++;
      $display("FAIL unr_repeat: got=%0d/%0d ones want=%0d/%0d",
               $countones(o0), $countones(o1), f[3][15:8], f[3][7:0]);
    end
    clear_flags();
  endtask

  task automatic test_mode_mute();
    logic [7:0]   s0;
    logic [255:0] o0, o1, e0, e1, m0, m1;
    s0 = 8'($urandom_range(2, 200));
    push({s0, 8'd255});
    mode   = 1'b0;
    enable = 1'b1;
    run_ticks(256);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) mode = 1'b1;
      tick();
      o0[i] = audio_out[1];
      o1[i] = audio_out[0];
    end
    total++;
    if (o0 !== pwm_pat(s0) || o1 !== pwm_pat(255)) begin
      bad++;
      $display("FAIL mode_pwm_hold: got=%0d/%0d ones want PWM %0d/255", $countones(o0), $countones(o1), s0);
    end
    capture(e0, e1);
    total++;
    if ($countones(e0) != int'(s0) || e0 === pwm_pat(s0)) begin
      bad++;
      $display("FAIL mode_sdm_start: got=%0d ones pwm_shape=%b want %0d ones, spread",
               $countones(e0), (e0 === pwm_pat(s0)), s0);
    end
    mute = 2'b01;
    tick();
    total++;
    if (audio_out[0] !== 1'b0) begin
      bad++;
      $display("FAIL mute_latency: ch1=%b want 0", audio_out[0]);
    end
    capture(m0, m1);
    total++;
    if (m1 !== '0 || $countones(m0) != int'(s0)) begin
      bad++;
      $display("FAIL mute_isolation: ch1 ones=%0d want 0, ch0 ones=%0d want %0d",
               $countones(m1), $countones(m0), s0);
    end
    mute   = 2'b00;
    enable = 1'b0;
    clear_flags();
  endtask

  initial begin
    enable     = 1'b0;
    mode       = 1'b0;
    pcm_valid  = 1'b0;
    pcm_frame  = '0;
    mute       = '0;
    status_clr = 1'b0;
    test_reset();
    test_pwm();
    test_sdm();
    test_overflow();
    test_mode_mute();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
